// File: rtl/mem_refill_unit.sv
// Cache-line refill engine: requests a line from memory, gathers the response beats
// into a line buffer and hands the line over. `CRITICAL_WORD_FIRST_EN` fetches the missed word first.
module mem_refill_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int WORD_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                                 clk,
  input  logic                                 arst_n,
  input  logic                                 i_halt,
  input  logic                                 i_initiate_mem_req,
  input  logic [ADDR_WIDTH-1:0]                i_miss_addr,
  input  logic                                 i_ready,
  output logic                                 o_mem_req_valid,
  output logic [ADDR_WIDTH-1:0]                o_mem_req_addr,
  input  logic                                 i_mem_req_ready,
  input  logic                                 i_mem_rsp_valid,
  input  logic [WORD_WIDTH-1:0]                i_mem_rsp_data,
  output logic                                 o_mem_rsp_ready,
  output logic                                 o_mem_data_received,
  output logic                                 o_valid,
  output logic [WORDS_PER_LINE*WORD_WIDTH-1:0] o_line_data,
  output logic [WORD_WIDTH-1:0]                o_missed_word
);

  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int LINE_W = WORDS_PER_LINE * WORD_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RECV = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

`ifdef CRITICAL_WORD_FIRST_EN
  localparam logic [ADDR_WIDTH-1:0] REQ_KEEP_MASK = ~ADDR_WIDTH'(3);
`else
  localparam logic [ADDR_WIDTH-1:0] REQ_KEEP_MASK = ~ADDR_WIDTH'((1 << (OFF_W + 2)) - 1);
`endif

  logic [1:0]            r_state;
  logic [1:0]            w_state_next;
  logic [OFF_W-1:0]      r_count;
  logic [ADDR_WIDTH-1:0] r_miss_addr;
  logic [OFF_W-1:0]      w_miss_off;
  logic [OFF_W-1:0]      w_start_off;
  logic [OFF_W-1:0]      w_slot;
  logic                  w_start;
  logic                  w_beat;
  logic [LINE_W-1:0]     w_line;

  assign w_miss_off = r_miss_addr[OFF_W+1:2];

`ifdef CRITICAL_WORD_FIRST_EN
  assign w_start_off = w_miss_off;
`else
  assign w_start_off = '0;
`endif

  // Slot index is OFF_W bits wide, so the addition wraps modulo the line length.
  assign w_slot  = w_start_off + r_count;
  assign w_start = (r_state == S_IDLE) && i_initiate_mem_req && !i_halt;
  assign w_beat  = (r_state == S_RECV) && i_mem_rsp_valid && !i_halt;

  always_comb begin
    w_state_next = r_state;
    if (!i_halt) begin
      case (r_state)
        S_IDLE: if (i_initiate_mem_req) w_state_next = S_REQ;
        S_REQ:  if (i_mem_req_ready) w_state_next = S_RECV;
        S_RECV: if (i_mem_rsp_valid && (r_count == OFF_W'(WORDS_PER_LINE - 1))) w_state_next = S_DONE;
        S_DONE: if (i_ready) w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_miss_addr <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_miss_addr <= i_miss_addr;
        r_count     <= '0;
      end else if (w_beat) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_slot
      logic [WORD_WIDTH-1:0] r_word;

      always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
          r_word <= '0;
        end else if (w_beat && (w_slot == OFF_W'(gi))) begin
          r_word <= i_mem_rsp_data;
        end
      end

      assign w_line[gi*WORD_WIDTH +: WORD_WIDTH] = r_word;
    end
  endgenerate

  always_comb begin
    o_missed_word = '0;
    for (int i = 0; i < WORDS_PER_LINE; i++) begin
      if (w_miss_off == OFF_W'(i)) o_missed_word = w_line[i*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  assign o_line_data         = w_line;
  assign o_mem_req_valid     = (r_state == S_REQ);
  assign o_mem_req_addr      = r_miss_addr & REQ_KEEP_MASK;
  assign o_mem_rsp_ready     = (r_state == S_RECV) && !i_halt;
  assign o_mem_data_received = (r_state == S_DONE);
  assign o_valid             = (r_state == S_DONE);

endmodule

// File: tb/tb_mem_refill_unit.sv
// Bench for mem_refill_unit: directed refill scenarios plus random refills checked
// against a slot-order model of the line buffer.
module tb_mem_refill_unit;

  localparam int AW = 32;
  localparam int WW = 32;
  localparam int NW = 4;
  localparam int LW = NW * WW;

`ifdef CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          arst_n;
  logic          i_halt;
  logic          i_initiate_mem_req;
  logic [AW-1:0] i_miss_addr;
  logic          i_ready;
  logic          o_mem_req_valid;
  logic [AW-1:0] o_mem_req_addr;
  logic          i_mem_req_ready;
  logic          i_mem_rsp_valid;
  logic [WW-1:0] i_mem_rsp_data;
  logic          o_mem_rsp_ready;
  logic          o_mem_data_received;
  logic          o_valid;
  logic [LW-1:0] o_line_data;
  logic [WW-1:0] o_missed_word;

  int vectors = 0;
  int miscompares = 0;

  logic [WW-1:0] beats [NW];
  logic [LW-1:0] exp_line;
  logic [WW-1:0] exp_missed;
  logic [AW-1:0] exp_req_addr;

  always #5 clk = ~clk;

  mem_refill_unit #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .WORDS_PER_LINE(NW)) dut (
    .clk                 (clk),
    .arst_n              (arst_n),
    .i_halt              (i_halt),
    .i_initiate_mem_req  (i_initiate_mem_req),
    .i_miss_addr         (i_miss_addr),
    .i_ready             (i_ready),
    .o_mem_req_valid     (o_mem_req_valid),
    .o_mem_req_addr      (o_mem_req_addr),
    .i_mem_req_ready     (i_mem_req_ready),
    .i_mem_rsp_valid     (i_mem_rsp_valid),
    .i_mem_rsp_data      (i_mem_rsp_data),
    .o_mem_rsp_ready     (o_mem_rsp_ready),
    .o_mem_data_received (o_mem_data_received),
    .o_valid             (o_valid),
    .o_line_data         (o_line_data),
    .o_missed_word       (o_missed_word)
  );

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: line offset in bytes is word offset * 4; beat k lands at (start + k) mod NW.
  task automatic build_model(input logic [AW-1:0] addr);
    int off;
    int start;
    int line_bytes;
    line_bytes = NW * 4;
    off = (addr % line_bytes) / 4;
    start = CWF ? off : 0;
    exp_req_addr = CWF ? (addr - (addr % 4)) : (addr - (addr % line_bytes));
    exp_line = '0;
    for (int k = 0; k < NW; k++) exp_line[((start + k) % NW) * WW +: WW] = beats[k];
    exp_missed = exp_line[off * WW +: WW];
  endtask

  task automatic refill(input logic [AW-1:0] addr, input int req_wait, input bit req_halt,
                        input int halt_beat, input int done_wait, input bit gaps);
    build_model(addr);
    i_initiate_mem_req = 1'b1;
    i_miss_addr = addr;
    step();
    i_initiate_mem_req = 1'b0;
    i_miss_addr = $urandom;
    if (req_halt) begin
      i_halt = 1'b1;
      i_mem_req_ready = 1'b1;
      #1 chk("req_valid_halt", o_mem_req_valid, 1);
      step();
      i_halt = 1'b0;
      i_mem_req_ready = 1'b0;
    end
    for (int d = 0; d < req_wait; d++) begin
      i_mem_rsp_valid = 1'b1;
      i_mem_rsp_data = $urandom;
      #1;
      chk("req_valid_wait", o_mem_req_valid, 1);
      chk("req_addr_wait", o_mem_req_addr, exp_req_addr);
      chk("rsp_ready_in_req", o_mem_rsp_ready, 0);
      step();
    end
    i_mem_rsp_valid = 1'b0;
    i_mem_req_ready = 1'b1;
    #1;
    chk("req_valid", o_mem_req_valid, 1);
    chk("req_addr", o_mem_req_addr, exp_req_addr);
    step();
    i_mem_req_ready = 1'b0;
    #1 chk("req_valid_after_accept", o_mem_req_valid, 0);
    for (int k = 0; k < NW; k++) begin
      if (k == halt_beat) begin
        i_halt = 1'b1;
        i_mem_rsp_valid = 1'b1;
        i_mem_rsp_data = beats[k];
        #1 chk("rsp_ready_halt1", o_mem_rsp_ready, 0);
        step();
        #1 chk("rsp_ready_halt2", o_mem_rsp_ready, 0);
        step();
        i_halt = 1'b0;
      end
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        i_mem_rsp_valid = 1'b0;
        i_mem_rsp_data = $urandom;
        #1 chk("rsp_ready_gap", o_mem_rsp_ready, 1);
        chk("received_early", o_mem_data_received, 0);
        step();
      end
      i_mem_rsp_valid = 1'b1;
      i_mem_rsp_data = beats[k];
      #1 chk("rsp_ready_beat", o_mem_rsp_ready, 1);
      step();
    end
    i_mem_rsp_valid = 1'b0;
    #1;
    chk("data_received", o_mem_data_received, 1);
    chk("o_valid", o_valid, 1);
    chk("line_data", o_line_data, exp_line);
    chk("missed_word", o_missed_word, exp_missed);
    for (int d = 0; d < done_wait; d++) begin
      i_initiate_mem_req = (d == 0);
      i_miss_addr = $urandom;
      #1;
      chk("received_held", o_mem_data_received, 1);
      chk("valid_held", o_valid, 1);
      step();
      i_initiate_mem_req = 1'b0;
    end
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    #1;
    chk("received_cleared", o_mem_data_received, 0);
    chk("idle_no_req", o_mem_req_valid, 0);
    chk("line_hold", o_line_data, exp_line);
    chk("missed_hold", o_missed_word, exp_missed);
    step();
    #1 chk("idle_stays", o_mem_req_valid, 0);
  endtask

  initial begin
    arst_n = 1'b0;
    i_halt = 1'b0;
    i_initiate_mem_req = 1'b0;
    i_miss_addr = '0;
    i_ready = 1'b0;
    i_mem_req_ready = 1'b0;
    i_mem_rsp_valid = 1'b0;
    i_mem_rsp_data = '0;
    #12;
    chk("rst_req_valid", o_mem_req_valid, 0);
    chk("rst_req_addr", o_mem_req_addr, 0);
    chk("rst_received", o_mem_data_received, 0);
    chk("rst_line", o_line_data, 0);
    arst_n = 1'b1;
    step();

    // Directed miss at 0x1008 with beats A,B,C,D
    beats[0] = 32'hAAAA_0001; beats[1] = 32'hBBBB_0002;
    beats[2] = 32'hCCCC_0003; beats[3] = 32'hDDDD_0004;
    refill(32'h0000_1008, 0, 1'b0, -1, 0, 1'b0);
    if (CWF) begin
      chk("dir_line_cwf", o_line_data, {beats[1], beats[0], beats[3], beats[2]});
      chk("dir_missed_cwf", o_missed_word, beats[0]);
    end else begin
      chk("dir_line", o_line_data, {beats[3], beats[2], beats[1], beats[0]});
      chk("dir_missed", o_missed_word, beats[2]);
    end

    // Request stalled 3 cycles, halt before beat 3, consumer stalls 5 cycles in DONE
    for (int k = 0; k < NW; k++) beats[k] = $urandom;
    refill(32'h0000_4C14, 3, 1'b1, 2, 5, 1'b0);

    // Reset in the middle of a burst
    for (int k = 0; k < NW; k++) beats[k] = $urandom;
    i_initiate_mem_req = 1'b1;
    i_miss_addr = 32'h0000_300C;
    step();
    i_initiate_mem_req = 1'b0;
    i_mem_req_ready = 1'b1;
    step();
    i_mem_req_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_mem_rsp_valid = 1'b1;
      i_mem_rsp_data = beats[k];
      step();
    end
    arst_n = 1'b0;
    #1;
    chk("arst_req_valid", o_mem_req_valid, 0);
    chk("arst_req_addr", o_mem_req_addr, 0);
    chk("arst_rsp_ready", o_mem_rsp_ready, 0);
    chk("arst_received", o_mem_data_received, 0);
    chk("arst_valid", o_valid, 0);
    chk("arst_line", o_line_data, 0);
    chk("arst_missed", o_missed_word, 0);
    i_mem_rsp_valid = 1'b0;
    step();
    arst_n = 1'b1;
    step();
    for (int k = 0; k < NW; k++) beats[k] = $urandom;
    refill(32'h0000_2000, 1, 1'b0, -1, 1, 1'b0);

    // Random refills
    for (int n = 0; n < 24; n++) begin
      for (int k = 0; k < NW; k++) beats[k] = $urandom;
      refill($urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             $urandom_range(0, NW), $urandom_range(0, 3), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
